dmi_ctrl: RTL and testbench
===========================

Name: dmi_ctrl

Overview:
- Sequences Debug Module Interface (DMI) transactions between the JTAG DTM (dtm_jtag) and the Debug Module (DM) register bus.
- Latches each DTM request and runs a valid/ready request and response handshake to the DM.
- Returns read data and a RISC-V-style op status to the DTM.
- Tracks the sticky busy/failed condition that dtmcs.dmireset clears.
- Lives in the test-clock domain alongside dtm_jtag.

Parameters:
- ABITS, 7, DMI address width; matches dtm_jtag address field [40:34].
- TIMEOUT, 64, max tclk cycles waiting for DM response (used only with the optional feature).

Ports:
- tclk  in  1  test clock; all logic on posedge.
- trst  in  1  asynchronous active-low reset.
- dmi_start  in  1  one-cycle pulse from DTM: new op latched.
- dmi_op  in  2  0 nop, 1 read, 2 write, 3 reserved.
- dmi_address  in  ABITS  DM register address.
- dmi_data_o  in  32  write data from DTM.
- dmi_data_i  out  32  read data to DTM.
- dmi_resp  out  2  status of last op: 0 ok, 2 failed, 3 busy.
- dmi_finish  out  1  one-cycle pulse: op complete, dmi_data_i/dmi_resp valid.
- dmi_reset  in  1  dtmcs.dmireset pulse: clears sticky status.
- dmi_hardreset  in  1  dtmcs.dmihardreset pulse: aborts in-flight op.
- dm_req_valid  out  1  request to DM.
- dm_req_ready  in  1  DM accepts request.
- dm_req_write  out  1  1 write, 0 read.
- dm_req_addr  out  ABITS  request address.
- dm_req_wdata  out  32  request write data.
- dm_rsp_valid  in  1  DM response strobe; DM holds no backpressure.
- dm_rsp_rdata  in  32  response read data.
- dm_rsp_error  in  1  DM reports access error.

Behaviour:
- Reset (trst low, async):
  - State is IDLE.
  - All outputs are 0: dmi_data_i=0, dmi_resp=0, dmi_finish=0, dm_req_valid=0, dm_req_write=0, dm_req_addr=0, dm_req_wdata=0.
  - sticky=0.
  - Reset mid-transaction drops dm_req_valid immediately. No finish is generated.
- States are IDLE, REQ, WAIT_RSP, DONE.
- IDLE + dmi_start:
  - sticky!=0: no DM access. Go to DONE. dmi_resp=sticky, dmi_data_i unchanged.
  - op=0 (nop): go to DONE, dmi_resp=0, dmi_data_i unchanged.
  - op=3: go to DONE, dmi_resp=2, sticky=2.
  - op=1/2: latch address, data and write flag into dm_req_*. Go to REQ. dm_req_valid=1 the cycle after dmi_start.
- REQ:
  - dm_req_valid and all dm_req_* are held stable until dm_req_ready.
  - On valid&&ready: drop valid next cycle, go to WAIT_RSP.
  - The DM may assert dm_rsp_valid in the same cycle as ready. That response is accepted and the FSM goes straight to DONE.
- WAIT_RSP:
  - On dm_rsp_valid: for a read, dmi_data_i=dm_rsp_rdata; for a write, dmi_data_i is unchanged.
  - If dm_rsp_error: dmi_resp=2 and sticky=2. Otherwise dmi_resp=0.
  - Go to DONE.
- DONE: dmi_finish=1 for exactly one cycle, then IDLE.
  - Minimum latency, read with ready and rsp in the same cycle: dmi_start at cycle N, req_valid at N+1, finish at N+2.
  - Minimum latency, nop: dmi_start at N, finish at N+1.
- dmi_start while not IDLE (overrun):
  - The new op is ignored and the in-flight op completes normally.
  - sticky=3. The completing finish reports dmi_resp=3.
- dmi_reset: sets sticky=0 at the next edge. Does not affect an in-flight op. If it coincides with a sticky set, the set wins.
- dmi_hardreset:
  - Forces IDLE and drops dm_req_valid.
  - Sets sticky=0, dmi_resp=0, and generates no finish.
  - A dmi_start in the same cycle is ignored.
- dmi_data_i and dmi_resp hold their values until the next completion.

Optional Feature:
- Macro DMI_CTRL_TIMEOUT_EN.
- Enabled:
  - An 8-bit-or-wider counter runs in REQ and WAIT_RSP.
  - On reaching TIMEOUT cycles without completion: drop dm_req_valid, go to DONE, dmi_resp=2, sticky=2.
  - The counter clears on entry to REQ.
  - A late dm_rsp_valid arriving in IDLE is ignored.
- Disabled: no counter; the FSM waits indefinitely and the TIMEOUT parameter is unused.

Test Plan:
- Reset: trst low mid-REQ -> dm_req_valid=0 immediately, dmi_finish never pulses, dmi_resp=0, dmi_data_i=0.
- Read: op=1, addr=0x11, DM ready after 2 cycles, rsp rdata=0x1BEEF001 -> dm_req_addr=0x11 and write=0 held while valid; finish one cycle after rsp; dmi_data_i=0x1BEEF001, dmi_resp=0.
- Write with error: op=2, addr=0x10, data=0xDEADBEEF, rsp_error=1 -> dm_req_wdata=0xDEADBEEF; dmi_resp=2. Next read, op=1 -> no dm_req_valid, finish with resp=2. After dmi_reset, a read succeeds with resp=0.
- Overrun: second dmi_start while in WAIT_RSP -> the single DM transaction completes with dmi_resp=3. Subsequent ops return 3 without DM access until dmi_reset.
- Nop/reserved: op=0 -> finish at N+1, resp=0, no dm_req_valid. op=3 -> finish at N+1, resp=2.
- DMI_CTRL_TIMEOUT_EN with TIMEOUT=8: dm_req_ready held 0 -> dm_req_valid drops after 8 cycles, finish with resp=2. Without the macro, the FSM remains in REQ after 100 cycles.

Source files
------------

// File: rtl/dmi_ctrl.sv
// DMI transaction sequencer between dtm_jtag and the Debug Module register bus (tclk domain).
// Optional response timeout enabled by defining DMI_CTRL_TIMEOUT_EN.
module dmi_ctrl #(
  parameter int ABITS   = 7,
  parameter int TIMEOUT = 64
) (
  input  logic             tclk,
  input  logic             trst,
  input  logic             dmi_start,
  input  logic [1:0]       dmi_op,
  input  logic [ABITS-1:0] dmi_address,
  input  logic [31:0]      dmi_data_o,
  output logic [31:0]      dmi_data_i,
  output logic [1:0]       dmi_resp,
  output logic             dmi_finish,
  input  logic             dmi_reset,
  input  logic             dmi_hardreset,
  output logic             dm_req_valid,
  input  logic             dm_req_ready,
  output logic             dm_req_write,
  output logic [ABITS-1:0] dm_req_addr,
  output logic [31:0]      dm_req_wdata,
  input  logic             dm_rsp_valid,
  input  logic [31:0]      dm_rsp_rdata,
  input  logic             dm_rsp_error
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t     state;
  logic [1:0] sticky;
  logic       overrun;
  logic       busy;
  logic [1:0] cmpl_resp;
  logic       tmo_hit;

`ifdef DMI_CTRL_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] tmo_cnt;
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // An overrun seen now or earlier in this op turns its completion into busy
  assign overrun   = dmi_start && (state != IDLE);
  assign busy      = overrun || (sticky == 2'd3);
  assign cmpl_resp = busy ? 2'd3 : (dm_rsp_error ? 2'd2 : 2'd0);

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      state        <= IDLE;
      sticky       <= 2'd0;
      dmi_data_i   <= 32'd0;
      dmi_resp     <= 2'd0;
      dmi_finish   <= 1'b0;
      dm_req_valid <= 1'b0;
      dm_req_write <= 1'b0;
      dm_req_addr  <= '0;
      dm_req_wdata <= 32'd0;
`ifdef DMI_CTRL_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else if (dmi_hardreset) begin
      state        <= IDLE;
      sticky       <= 2'd0;
      dmi_resp     <= 2'd0;
      dmi_finish   <= 1'b0;
      dm_req_valid <= 1'b0;
    end else begin
      dmi_finish <= 1'b0;
      // Later assignments to sticky override the clear, so a set always wins
      if (dmi_reset) sticky <= 2'd0;
      if (overrun)   sticky <= 2'd3;
`ifdef DMI_CTRL_TIMEOUT_EN
      if (state == REQ || state == WAIT_RSP) tmo_cnt <= tmo_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (dmi_start) begin
            if (sticky != 2'd0) begin
              state      <= DONE;
              dmi_finish <= 1'b1;
              dmi_resp   <= sticky;
            end else if (dmi_op == 2'd0) begin
              state      <= DONE;
              dmi_finish <= 1'b1;
              dmi_resp   <= 2'd0;
            end else if (dmi_op == 2'd3) begin
              state      <= DONE;
              dmi_finish <= 1'b1;
              dmi_resp   <= 2'd2;
              sticky     <= 2'd2;
            end else begin
              state        <= REQ;
              dm_req_valid <= 1'b1;
              dm_req_write <= (dmi_op == 2'd2);
              dm_req_addr  <= dmi_address;
              dm_req_wdata <= dmi_data_o;
`ifdef DMI_CTRL_TIMEOUT_EN
              tmo_cnt      <= '0;
`endif
            end
          end
        end
        REQ, WAIT_RSP: begin
          if ((state == REQ && dm_req_ready && dm_rsp_valid) ||
              (state == WAIT_RSP && dm_rsp_valid)) begin
            state        <= DONE;
            dm_req_valid <= 1'b0;
            dmi_finish   <= 1'b1;
            dmi_resp     <= cmpl_resp;
            if (!dm_req_write) dmi_data_i <= dm_rsp_rdata;
            if (cmpl_resp != 2'd0) sticky <= cmpl_resp;
          end else if (state == REQ && dm_req_ready) begin
            state        <= WAIT_RSP;
            dm_req_valid <= 1'b0;
          end else if (tmo_hit) begin
            state        <= DONE;
            dm_req_valid <= 1'b0;
            dmi_finish   <= 1'b1;
            dmi_resp     <= 2'd2;
            sticky       <= 2'd2;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_ctrl.sv
// Directed self-checking bench for dmi_ctrl; inputs change 1ns after posedge, outputs checked there too.
module tb_dmi_ctrl;

  logic        tclk = 1'b0;
  logic        trst = 1'b0;
  logic        dmi_start = 1'b0;
  logic [1:0]  dmi_op = 2'd0;
  logic [6:0]  dmi_address = 7'd0;
  logic [31:0] dmi_data_o = 32'd0;
  logic [31:0] dmi_data_i;
  logic [1:0]  dmi_resp;
  logic        dmi_finish;
  logic        dmi_reset = 1'b0;
  logic        dmi_hardreset = 1'b0;
  logic        dm_req_valid;
  logic        dm_req_ready = 1'b0;
  logic        dm_req_write;
  logic [6:0]  dm_req_addr;
  logic [31:0] dm_req_wdata;
  logic        dm_rsp_valid = 1'b0;
  logic [31:0] dm_rsp_rdata = 32'd0;
  logic        dm_rsp_error = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  dmi_ctrl #(.ABITS(7), .TIMEOUT(8)) dut (
    .tclk(tclk), .trst(trst),
    .dmi_start(dmi_start), .dmi_op(dmi_op), .dmi_address(dmi_address),
    .dmi_data_o(dmi_data_o), .dmi_data_i(dmi_data_i), .dmi_resp(dmi_resp),
    .dmi_finish(dmi_finish), .dmi_reset(dmi_reset), .dmi_hardreset(dmi_hardreset),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_req_write(dm_req_write), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_rsp_valid(dm_rsp_valid),
    .dm_rsp_rdata(dm_rsp_rdata), .dm_rsp_error(dm_rsp_error)
  );

  always #5 tclk = ~tclk;

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [1:0] op,
                               input logic [6:0] addr, input logic [31:0] data);
    dmi_start   = start;
    dmi_op      = op;
    dmi_address = addr;
    dmi_data_o  = data;
  endtask

  task automatic setDm(input logic ready, input logic rvalid,
                       input logic [31:0] rdata, input logic err);
    dm_req_ready = ready;
    dm_rsp_valid = rvalid;
    dm_rsp_rdata = rdata;
    dm_rsp_error = err;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pulseDmiReset();
    dmi_reset = 1'b1;
    tick();
    dmi_reset = 1'b0;
  endtask

  initial begin
    logic finish_seen;

    tick();
    tick();
    checkOutput("rst_valid", {31'd0, dm_req_valid}, 32'd0);
    checkOutput("rst_finish", {31'd0, dmi_finish}, 32'd0);
    checkOutput("rst_resp", {30'd0, dmi_resp}, 32'd0);
    checkOutput("rst_data", dmi_data_i, 32'd0);
    checkOutput("rst_addr", {25'd0, dm_req_addr}, 32'd0);
    trst = 1'b1;
    tick();

    // Read with DM ready two cycles after request
    applyStimulus(1'b1, 2'd1, 7'h11, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("rd_valid", {31'd0, dm_req_valid}, 32'd1);
    checkOutput("rd_addr", {25'd0, dm_req_addr}, 32'h11);
    checkOutput("rd_write", {31'd0, dm_req_write}, 32'd0);
    tick();
    checkOutput("rd_valid_hold", {31'd0, dm_req_valid}, 32'd1);
    checkOutput("rd_addr_hold", {25'd0, dm_req_addr}, 32'h11);
    setDm(1'b1, 1'b0, 32'd0, 1'b0);
    tick();
    setDm(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd_valid_drop", {31'd0, dm_req_valid}, 32'd0);
    checkOutput("rd_no_early_fin", {31'd0, dmi_finish}, 32'd0);
    setDm(1'b0, 1'b1, 32'h1BEEF001, 1'b0);
    tick();
    setDm(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("rd_finish", {31'd0, dmi_finish}, 32'd1);
    checkOutput("rd_data", dmi_data_i, 32'h1BEEF001);
    checkOutput("rd_resp", {30'd0, dmi_resp}, 32'd0);
    tick();
    checkOutput("rd_finish_once", {31'd0, dmi_finish}, 32'd0);

    // Write with DM error, ready and response in the same cycle
    applyStimulus(1'b1, 2'd2, 7'h10, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("wr_valid", {31'd0, dm_req_valid}, 32'd1);
    checkOutput("wr_write", {31'd0, dm_req_write}, 32'd1);
    checkOutput("wr_wdata", dm_req_wdata, 32'hDEADBEEF);
    setDm(1'b1, 1'b1, 32'h55555555, 1'b1);
    tick();
    setDm(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("wr_finish", {31'd0, dmi_finish}, 32'd1);
    checkOutput("wr_resp", {30'd0, dmi_resp}, 32'd2);
    checkOutput("wr_data_keep", dmi_data_i, 32'h1BEEF001);
    tick();

    // Sticky failure blocks the next read
    applyStimulus(1'b1, 2'd1, 7'h11, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("stk_no_valid", {31'd0, dm_req_valid}, 32'd0);
    checkOutput("stk_finish", {31'd0, dmi_finish}, 32'd1);
    checkOutput("stk_resp", {30'd0, dmi_resp}, 32'd2);
    tick();
    pulseDmiReset();
    applyStimulus(1'b1, 2'd1, 7'h05, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("clr_valid", {31'd0, dm_req_valid}, 32'd1);
    setDm(1'b1, 1'b1, 32'hCAFE0005, 1'b0);
    tick();
    setDm(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("clr_finish", {31'd0, dmi_finish}, 32'd1);
    checkOutput("clr_resp", {30'd0, dmi_resp}, 32'd0);
    checkOutput("clr_data", dmi_data_i, 32'hCAFE0005);
    tick();

    // Overrun during WAIT_RSP
    applyStimulus(1'b1, 2'd1, 7'h20, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    setDm(1'b1, 1'b0, 32'd0, 1'b0);
    tick();
    setDm(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 2'd2, 7'h33, 32'h0BADF00D);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("ovr_no_valid", {31'd0, dm_req_valid}, 32'd0);
    checkOutput("ovr_no_fin", {31'd0, dmi_finish}, 32'd0);
    checkOutput("ovr_addr_keep", {25'd0, dm_req_addr}, 32'h20);
    setDm(1'b0, 1'b1, 32'h12345678, 1'b0);
    tick();
    setDm(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("ovr_finish", {31'd0, dmi_finish}, 32'd1);
    checkOutput("ovr_resp", {30'd0, dmi_resp}, 32'd3);
    checkOutput("ovr_data", dmi_data_i, 32'h12345678);
    tick();
    applyStimulus(1'b1, 2'd1, 7'h20, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("busy_no_valid", {31'd0, dm_req_valid}, 32'd0);
    checkOutput("busy_resp", {30'd0, dmi_resp}, 32'd3);
    checkOutput("busy_finish", {31'd0, dmi_finish}, 32'd1);
    tick();
    pulseDmiReset();

    // Nop and reserved op
    applyStimulus(1'b1, 2'd0, 7'h00, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("nop_finish", {31'd0, dmi_finish}, 32'd1);
    checkOutput("nop_resp", {30'd0, dmi_resp}, 32'd0);
    checkOutput("nop_no_valid", {31'd0, dm_req_valid}, 32'd0);
    tick();
    applyStimulus(1'b1, 2'd3, 7'h00, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("rsv_finish", {31'd0, dmi_finish}, 32'd1);
    checkOutput("rsv_resp", {30'd0, dmi_resp}, 32'd2);
    checkOutput("rsv_no_valid", {31'd0, dm_req_valid}, 32'd0);
    tick();

    // Hardreset clears sticky and aborts an in-flight read
    dmi_hardreset = 1'b1;
    tick();
    dmi_hardreset = 1'b0;
    checkOutput("hrst_resp", {30'd0, dmi_resp}, 32'd0);
    applyStimulus(1'b1, 2'd1, 7'h44, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("hrst_sticky_clr", {31'd0, dm_req_valid}, 32'd1);
    dmi_hardreset = 1'b1;
    tick();
    dmi_hardreset = 1'b0;
    checkOutput("hrst_valid", {31'd0, dm_req_valid}, 32'd0);
    checkOutput("hrst_finish", {31'd0, dmi_finish}, 32'd0);
    tick();
    checkOutput("hrst_no_fin", {31'd0, dmi_finish}, 32'd0);

    // DM never ready: timeout after 8 cycles, or indefinite wait
    applyStimulus(1'b1, 2'd1, 7'h66, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    finish_seen = 1'b0;
`ifdef DMI_CTRL_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      finish_seen |= dmi_finish;
      tick();
    end
    checkOutput("tmo_valid_8", {31'd0, dm_req_valid}, 32'd1);
    checkOutput("tmo_no_early", {31'd0, finish_seen}, 32'd0);
    tick();
    checkOutput("tmo_valid_drop", {31'd0, dm_req_valid}, 32'd0);
    checkOutput("tmo_finish", {31'd0, dmi_finish}, 32'd1);
    checkOutput("tmo_resp", {30'd0, dmi_resp}, 32'd2);
    tick();
    pulseDmiReset();
`else
    for (int i = 0; i < 100; i++) begin
      finish_seen |= dmi_finish;
      tick();
    end
    checkOutput("wait_valid", {31'd0, dm_req_valid}, 32'd1);
    checkOutput("wait_no_fin", {31'd0, finish_seen}, 32'd0);
    dmi_hardreset = 1'b1;
    tick();
    dmi_hardreset = 1'b0;
`endif

    // Async reset in the middle of REQ
    applyStimulus(1'b1, 2'd1, 7'h77, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 7'h00, 32'd0);
    checkOutput("mrst_pre_valid", {31'd0, dm_req_valid}, 32'd1);
    #2;
    trst = 1'b0;
    #1;
    checkOutput("mrst_valid", {31'd0, dm_req_valid}, 32'd0);
    checkOutput("mrst_resp", {30'd0, dmi_resp}, 32'd0);
    checkOutput("mrst_data", dmi_data_i, 32'd0);
    finish_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      finish_seen |= dmi_finish;
    end
    trst = 1'b1;
    tick();
    finish_seen |= dmi_finish;
    checkOutput("mrst_no_fin", {31'd0, finish_seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
